// File: rtl/wb_arbiter_pkg.sv
// Shared write-back types and register constants.
// Used by the arbiter, its FIFO and the bench.
package wb_arbiter_pkg;

    localparam logic [4:0] REG_RA   = 5'd31;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         WB_W     = 32;

    typedef struct packed {
        logic [4:0]      rd;
        logic [WB_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back bus: ALU/MDU producers in, register-file port
// and hazard-unit status out.
interface wb_arbiter_if #(
    parameter int W = 32
);
    logic         alu_valid;
    logic [4:0]   alu_rd;
    logic         alu_jal;
    logic [W-1:0] alu_data;
    logic         mdu_issue;
    logic [4:0]   mdu_issue_rd;
    logic         mdu_valid;
    logic         mdu_ready;
    logic [4:0]   mdu_rd;
    logic [W-1:0] mdu_data;
    logic         regwrite;
    logic         jal_ra;
    logic [4:0]   wr_out;
    logic [W-1:0] write_data_out;
    logic [31:0]  busy_mask;
    logic         stall_req;

    modport slave (
        input  alu_valid, alu_rd, alu_jal, alu_data,
        input  mdu_issue, mdu_issue_rd,
        input  mdu_valid, mdu_rd, mdu_data,
        output mdu_ready,
        output regwrite, jal_ra, wr_out, write_data_out,
        output busy_mask, stall_req
    );

    modport master (
        output alu_valid, alu_rd, alu_jal, alu_data,
        output mdu_issue, mdu_issue_rd,
        output mdu_valid, mdu_rd, mdu_data,
        input  mdu_ready,
        input  regwrite, jal_ra, wr_out, write_data_out,
        input  busy_mask, stall_req
    );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Small synchronous FIFO holding MDU results that could
// not commit on the cycle they arrived.
module wb_fifo #(
    parameter int DW    = 37,
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

    // Storage array; contents are meaningless while cnt is 0.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally; cnt separates full from empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      cnt <= cnt + (AW+1)'(1);
            else if (!push && pop) cnt <= cnt - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU first, then queued
// MDU results, then MDU bypass; tracks pending MDU dests.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int W          = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    wb_arbiter_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 5 + W;

    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic [EW-1:0] head;
    logic [4:0]    head_rd;
    logic [W-1:0]  head_data;
    logic          xfer;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          commit_mdu;
    logic [4:0]    commit_rd;
    logic [W-1:0]  commit_data;
    logic [31:0]   busy_q;
    logic [31:0]   busy_d;
    logic          rw_q;
    logic          jal_q;
    logic [4:0]    wr_q;
    logic [W-1:0]  wd_q;

    assign head_rd   = head[EW-1 -: 5];
    assign head_data = head[W-1:0];

    assign xfer   = bus.mdu_valid & ~full;
    assign bypass = xfer & empty & ~bus.alu_valid;
    assign push   = xfer & ~bypass;
    assign pop    = ~bus.alu_valid & ~empty;

    assign bus.mdu_ready      = ~full;
    assign bus.stall_req      = (count == (AW+1)'(FIFO_DEPTH));
    assign bus.busy_mask      = busy_q;
    assign bus.regwrite       = rw_q;
    assign bus.jal_ra         = jal_q;
    assign bus.wr_out         = wr_q;
    assign bus.write_data_out = wd_q;

    wb_fifo #(
        .DW    (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({bus.mdu_rd, bus.mdu_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Pick the MDU result (if any) and next scoreboard value.
    always_comb begin
        commit_mdu  = 1'b0;
        commit_rd   = REG_ZERO;
        commit_data = '0;
        if (pop) begin
            commit_mdu  = 1'b1;
            commit_rd   = head_rd;
            commit_data = head_data;
        end else if (bypass) begin
            commit_mdu  = 1'b1;
            commit_rd   = bus.mdu_rd;
            commit_data = bus.mdu_data;
        end
        busy_d = busy_q;
        if (commit_mdu) busy_d[commit_rd] = 1'b0;
        if (bus.mdu_issue && bus.mdu_issue_rd != REG_ZERO)
            busy_d[bus.mdu_issue_rd] = 1'b1;
    end

    // Output registers, stable ahead of the negedge RF write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rw_q  <= 1'b0;
            jal_q <= 1'b0;
            wr_q  <= REG_ZERO;
            wd_q  <= '0;
        end else if (bus.alu_valid) begin
            jal_q <= bus.alu_jal;
            wr_q  <= bus.alu_jal ? REG_RA : bus.alu_rd;
            rw_q  <= bus.alu_jal | (bus.alu_rd != REG_ZERO);
            wd_q  <= bus.alu_data;
        end else if (commit_mdu) begin
            jal_q <= 1'b0;
            wr_q  <= commit_rd;
            rw_q  <= (commit_rd != REG_ZERO);
            wd_q  <= commit_data;
        end else begin
            rw_q  <= 1'b0;
            jal_q <= 1'b0;
        end
    end

    // Scoreboard of destinations with MDU results outstanding.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_d;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writer side of the register-file write port: merges single-cycle ALU/JAL results and multi-cycle MDU (mult/div) results into the one port.
- Drives regwrite / jal_ra / wr / write_data, all registered on posedge, so they are stable before the register file's negedge write.
- Buffers MDU results in a small FIFO.
- Keeps a scoreboard of destination registers with MDU results still outstanding, for the hazard unit.

Parameters:
- W, 32, data width (matches register file W).
- FIFO_DEPTH, 2, MDU result FIFO entries (power of 2, >=2).

Ports:
- clock  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- alu_valid  in  1  ALU result present this cycle; always accepted.
- alu_rd  in  5  ALU destination register.
- alu_jal  in  1  result is a JAL link value (destination forced to 31).
- alu_data  in  W  ALU result.
- mdu_issue  in  1  an MDU op is dispatched this cycle.
- mdu_issue_rd  in  5  destination register of the dispatched MDU op.
- mdu_valid  in  1  MDU result offered.
- mdu_ready  out  1  MDU result accepted (valid&ready = transfer).
- mdu_rd  in  5  MDU result destination.
- mdu_data  in  W  MDU result.
- regwrite  out  1  register-file write enable.
- jal_ra  out  1  register-file JAL link select.
- wr_out  out  5  register-file write address.
- write_data_out  out  W  register-file write data.
- busy_mask  out  32  bit r = 1 while an MDU result for r is outstanding.
- stall_req  out  1  request upstream to hold ALU results (FIFO full).

Behaviour:
- Reset (reset=0, async): regwrite=0, jal_ra=0, wr_out=0, write_data_out=0, busy_mask=0, FIFO empty, stall_req=0. mdu_ready=1 (combinational, !full).
- Write-source priority per cycle:
  - 1) alu_valid.
  - 2) FIFO head.
  - 3) mdu_valid bypass, taken only when the FIFO is empty.
- The winner is loaded into the output registers at posedge; latency exactly 1 cycle.
- Idle cycle: regwrite=0; wr_out and write_data_out hold their last value.
- ALU commit: jal_ra=alu_jal; wr_out = alu_jal ? 31 : alu_rd; regwrite = alu_jal | (alu_rd!=0).
- MDU commit: jal_ra=0; regwrite=(rd!=0); wr_out=rd.
- A result with rd=0 (and not JAL) is consumed with regwrite=0; r0 is never written.
- MDU transfer when mdu_valid & mdu_ready:
  - Bypass if the FIFO is empty and alu_valid=0.
  - Otherwise push into the FIFO.
  - Same-cycle push and pop allowed; occupancy is unchanged.
- mdu_ready = !full. When full, mdu_valid is ignored and the MDU must hold its data.
- Pop occurs only on a cycle with alu_valid=0.
- stall_req = full (combinational). Upstream must drop alu_valid by the next cycle so the FIFO drains.
- An alu_valid received while stall_req=1 is still committed; it is never lost.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally; a separate count register (log2+1 bits) distinguishes full from empty.
- Scoreboard:
  - mdu_issue sets bit mdu_issue_rd, unless rd=0.
  - The bit clears on the posedge the matching MDU result is committed to the output registers.
  - Same rd set and clear in one cycle: set wins.
  - ALU commits never modify busy_mask; WAW handling belongs to the hazard unit.
- MDU results commit in arrival order (FIFO order preserved).
- Reset asserted mid-operation: FIFO contents and busy_mask are discarded immediately; any in-flight MDU result is dropped.

Decomposition:
- Shared datapath package:
  - REG_RA = 5'd31.
  - REG_ZERO = 5'd0.
  - A wb_entry struct {rd[4:0], data[W-1:0]}.
- One natural sub-module: wb_fifo (parameterised synchronous FIFO with push/pop/full/empty/count, async active-low reset), instantiated once for MDU results.
- The arbiter, output registers and scoreboard stay in wb_arbiter.

Test Plan:
- After reset release: alu_valid=1, alu_rd=5, alu_data=0x1234 -> next cycle regwrite=1, wr_out=5, write_data_out=0x1234, jal_ra=0.
- alu_valid=1, alu_jal=1, alu_rd=0, alu_data=0x00400008 -> regwrite=1, jal_ra=1, wr_out=31. Then alu_rd=0, alu_jal=0 -> regwrite=0.
- mdu_issue rd=8 -> busy_mask[8]=1. Then mdu_valid rd=8 data=0xCAFE with ALU idle -> regwrite=1, wr_out=8 next cycle and busy_mask[8]=0 on that same edge.
- ALU valid every cycle while the MDU offers results rd=9,10,11 -> first two accepted; mdu_ready=0 and stall_req=1 at full. Drop alu_valid -> commits 9, 10, then 11 in order, one per cycle.
- Same-cycle mdu_issue rd=12 with commit of an older rd=12 result -> busy_mask[12] remains 1.
- Assert reset with 2 FIFO entries and busy bits set -> outputs, busy_mask and count immediately 0. After release, no stale write appears.
